// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU control and the mul/div engine:
// ALU control codes, funct values, alu_op values and the mul/div state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } md_state_t;

endpackage

// File: rtl/alu_ctrl_muldiv_iter.sv
// Iterative multiply/divide engine with HI/LO registers.
// Only instanced when ALU_MULDIV_EN is defined.
//
// state | meaning
// IDLE  | waiting for a start; HI/LO hold the last result
// MUL   | shift-add, one multiplier bit per cycle, DATA_W cycles
// DIV   | restoring division, one quotient bit per cycle, DATA_W cycles
// FIX   | sign correction, HI/LO write, done pulse next cycle
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              is_div_i,
  input  logic              is_signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  md_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     mag_q, mag_d;
  logic                  res_neg_q, res_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic                  div0_q, div0_d;
  logic                  is_div_q, is_div_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  done_q, done_d;

  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W:0]       mul_sum;
  logic [DATA_W:0]       div_trial;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quot_fix, rem_fix;

  // Operand magnitudes: the most negative value maps to 2^(DATA_W-1), which still fits unsigned.
  assign a_neg = is_signed_i & a_i[DATA_W-1];
  assign b_neg = is_signed_i & b_i[DATA_W-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Multiply: acc = {partial product, remaining multiplier bits}; the carry lands in the top bit after the shift.
  assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mag_q} : '0);

  // Divide: acc = {partial remainder, remaining dividend bits}; trial-subtract the shifted remainder.
  assign div_trial = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, mag_q};

  assign prod_fix = res_neg_q ? -acc_q : acc_q;
  assign quot_fix = res_neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  // Next-state, datapath step and result write.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d     = '0;
          res_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          is_div_d  = is_div_i;
          div0_d    = is_div_i & (b_i == '0);
          if (!is_div_i) begin
            mag_d   = a_mag;
            acc_d   = {{DATA_W{1'b0}}, b_mag};
            state_d = MUL;
          end else if (b_i == '0) begin
            // Divide by zero: HI = dividend as given, LO = all ones.
            acc_d   = {a_i, {DATA_W{1'b1}}};
            state_d = FIX;
          end else begin
            mag_d   = b_mag;
            acc_d   = {{DATA_W{1'b0}}, a_mag};
            state_d = DIV;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      DIV: begin
        if (!div_trial[DATA_W]) acc_d = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        else                    acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          {hi_d, lo_d} = acc_q;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush abandons the operation without touching HI/LO.
    if (flush_i && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_q     <= mag_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decode plus optional iterative mul/div with HI/LO.
// The mul/div path, MFHI/MFLO mux and stall handshake exist only when
// ALU_MULDIV_EN is defined; otherwise those outputs are tied low.
module alu_ctrl_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              mf_sel,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              md_busy,
  output logic              md_done,
  output logic              stall
);

  logic [3:0] ctrl_code;

  // ALU operation decode from alu_op, falling back to funct for R-type.
  always_comb begin
    ctrl_code = ALU_ADD;
    case (alu_op)
      OP_ADD: ctrl_code = ALU_ADD;
      OP_SUB: ctrl_code = ALU_SUB;
      OP_OR:  ctrl_code = ALU_OR;
      default: begin
        case (funct)
          F_ADD, F_ADDU: ctrl_code = ALU_ADD;
          F_SUB, F_SUBU: ctrl_code = ALU_SUB;
          F_AND:         ctrl_code = ALU_AND;
          F_OR:          ctrl_code = ALU_OR;
          F_SLT:         ctrl_code = ALU_SLT;
          F_XOR:         ctrl_code = ALU_XOR;
          F_NOR:         ctrl_code = ALU_NOR;
          F_SLTU:        ctrl_code = ALU_SLTU;
          default:       ctrl_code = ALU_ADD;
        endcase
      end
    endcase
  end

  assign alu_ctrl = CTRL_W'(ctrl_code);

`ifdef ALU_MULDIV_EN
  logic is_rtype, is_mf, is_md, md_start;

  assign is_rtype = valid_in & (alu_op == OP_RTYPE);
  assign is_mf    = (funct == F_MFHI) | (funct == F_MFLO);
  // MULT/MULTU/DIV/DIVU share funct[5:2] = 0110; funct[1] selects divide, funct[0] unsigned.
  assign is_md    = (funct[5:2] == 4'b0110);
  assign md_start = is_rtype & is_md & ~md_busy & ~flush;

  muldiv_iter #(
    .DATA_W(DATA_W)
  ) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (md_start),
    .flush_i    (flush),
    .is_div_i   (funct[1]),
    .is_signed_i(~funct[0]),
    .a_i        (src_a),
    .b_i        (src_b),
    .hi_o       (hi),
    .lo_o       (lo),
    .busy_o     (md_busy),
    .done_o     (md_done)
  );

  assign mf_sel  = is_rtype & is_mf;
  assign mf_data = (funct == F_MFHI) ? hi : lo;
  // Only HI/LO consumers and further mul/div wait; plain ALU ops flow past a busy unit.
  assign stall   = is_rtype & (is_mf | is_md) & md_busy;
`else
  logic unused_disabled;

  assign unused_disabled = ^{clk, rst_n, valid_in, flush, src_a, src_b};
  assign mf_sel  = 1'b0;
  assign mf_data = '0;
  assign hi      = '0;
  assign lo      = '0;
  assign md_busy = 1'b0;
  assign md_done = 1'b0;
  assign stall   = 1'b0;
`endif

endmodule
